// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared ROM/RAM/GPIO bus; grant one cycle after request.
// Granted master's strobes/ready are muxed combinationally; each transaction ends with a one-cycle RELEASE.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_read,
  input  logic       m0_write,
  input  logic [7:0] m0_address,
  input  logic [7:0] m0_data_out,
  output logic [7:0] m0_data_in,
  output logic       m0_ready,
  input  logic       m1_read,
  input  logic       m1_write,
  input  logic [7:0] m1_address,
  input  logic [7:0] m1_data_out,
  output logic [7:0] m1_data_in,
  output logic       m1_ready,
  output logic       read,
  output logic       write,
  output logic [7:0] address,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic       ready,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_served, last_served_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_nxt;
  logic       m0_req, m1_req, cur_req;

  assign m0_req  = m0_read | m0_write;
  assign m1_req  = m1_read | m1_write;
  assign cur_req = (state == BUSY1) ? m1_req : m0_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wait_cnt    <= 8'h00;
      timeout     <= 1'b0;
      grant       <= 2'b00;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout     <= timeout_nxt;
      grant       <= (state_nxt == BUSY0) ? 2'b01 :
                     (state_nxt == BUSY1) ? 2'b10 : 2'b00;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    wait_cnt_nxt    = wait_cnt;
    timeout_nxt     = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_nxt = 8'h00;
        if (m0_req && m1_req) state_nxt = last_served ? BUSY0 : BUSY1;
        else if (m0_req)      state_nxt = BUSY0;
        else if (m1_req)      state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        // Completion wins over expiry in the same cycle; withdraw never raises timeout.
        if (ready || !cur_req || wait_cnt == CNT_LAST) begin
          state_nxt       = RELEASE;
          last_served_nxt = (state == BUSY1);
          wait_cnt_nxt    = 8'h00;
          timeout_nxt     = !ready && cur_req;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      RELEASE: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'h00;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = 8'h00;
    data_out   = 8'h00;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_data_in = 8'h00;
    m1_data_in = 8'h00;
    case (state)
      BUSY0: begin
        write      = m0_write;
        read       = m0_read & ~m0_write;
        address    = m0_address;
        data_out   = m0_data_out;
        m0_ready   = ready;
        m0_data_in = data_in;
      end
      BUSY1: begin
        write      = m1_write;
        read       = m1_read & ~m1_write;
        address    = m1_address;
        data_out   = m1_data_out;
        m1_ready   = ready;
        m1_data_in = data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction table plus hand-written corner sequences.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [7:0] m0_address = 8'h00, m0_data_out = 8'h00, m1_address = 8'h00, m1_data_out = 8'h00;
  logic [7:0] m0_data_in, m1_data_in, address, data_out;
  logic       m0_ready, m1_ready, read, write, timeout;
  logic [1:0] grant;
  logic [7:0] data_in = 8'h00;
  logic       ready = 1'b0;

  // slave model controls
  logic [7:0] slv_lat = 8'h00, slv_rdata = 8'h00;
  logic       force_rdy = 1'b0;
  int         slv_cnt = 0;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic m; logic tmo; logic [7:0] dat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic m; logic rd; logic wr; logic [7:0] addr; logic [7:0] wdat;
    logic [7:0] lat; logic [7:0] rdat;
    logic exp_rd; logic exp_wr; logic exp_tmo; int exp_busy;
  } vec_t;
  vec_t vecs[6];

  bus_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_ready(m0_ready),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_ready(m1_ready),
    .read(read), .write(write), .address(address), .data_out(data_out),
    .data_in(data_in), .ready(ready), .grant(grant), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Slave answers after slv_lat strobed cycles (8'hFF = never); force_rdy models a stray ready.
  always @(posedge clk) begin
    #2;
    if (read || write) begin
      if (slv_lat != 8'hFF && slv_cnt == int'(slv_lat)) begin
        ready = 1'b1; data_in = slv_rdata;
      end else begin
        ready = 1'b0; data_in = 8'h00;
      end
      slv_cnt++;
    end else begin
      ready   = force_rdy;
      data_in = force_rdy ? 8'hEE : 8'h00;
      slv_cnt = 0;
    end
  end

  // Scoreboard: every ready pulse or timeout pulse must match the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (m0_ready || m1_ready || timeout)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {29'd0, m1_ready, m0_ready, timeout}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind", {29'd0, m1_ready, m0_ready, timeout},
            e.tmo ? 32'd1 : (e.m ? 32'd4 : 32'd2));
        if (!e.tmo) chk("sb_data", e.m ? m1_data_in : m0_data_in, e.dat);
      end
    end
  end

  task automatic set_m(input logic m, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_data_out = d;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_data_out = d;
    end
  endtask

  task automatic wait_first_grant(input logic [1:0] g, input string nm);
    bit hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (grant != 2'b00) hit = 1'b1;
    end
    chk(nm, grant, g);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    int  busy;
    bit  rel, got_rdy;
    oh = v.m ? 2'b10 : 2'b01;
    busy = 0; rel = 1'b0; got_rdy = 1'b0;
    @(posedge clk); #1;
    slv_lat = v.lat; slv_rdata = v.rdat;
    set_m(v.m, v.rd, v.wr, v.addr, v.wdat);
    sb_q.push_back('{m: v.m, tmo: v.exp_tmo, dat: v.rdat});
    @(negedge clk);
    chk($sformatf("v%0d_grant_latency", idx), grant, 2'b00);
    for (int c = 0; c < 40 && !rel; c++) begin
      @(posedge clk); #1;
      if (got_rdy) set_m(v.m, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      if (grant == oh) begin
        busy++;
        if (busy == 1) begin
          chk($sformatf("v%0d_bus_rd", idx), read, v.exp_rd);
          chk($sformatf("v%0d_bus_wr", idx), write, v.exp_wr);
          chk($sformatf("v%0d_bus_addr", idx), address, v.addr);
          chk($sformatf("v%0d_bus_wdat", idx), data_out, v.wdat);
        end
        chk($sformatf("v%0d_other_idle", idx),
            v.m ? {m0_ready, m0_data_in} : {m1_ready, m1_data_in}, 32'd0);
        if (v.m ? m1_ready : m0_ready) got_rdy = 1'b1;
      end else begin
        rel = 1'b1;
        chk($sformatf("v%0d_busy_cycles", idx), busy, v.exp_busy);
        chk($sformatf("v%0d_rel_timeout", idx), timeout, v.exp_tmo);
        chk($sformatf("v%0d_rel_bus", idx), {grant, read, write, address, data_out}, 32'd0);
      end
    end
    if (!rel) chk($sformatf("v%0d_release_bound", idx), 32'd0, 32'd1);
    @(posedge clk); #1;
    set_m(v.m, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), {grant, timeout, m0_ready, m1_ready}, 32'd0);
  endtask

  initial begin
    int ng, last_c;
    // m, rd, wr, addr, wdat, lat, rdat, exp_rd, exp_wr, exp_tmo, exp_busy
    vecs[0] = '{m:0, rd:1, wr:0, addr:8'h10, wdat:8'h00, lat:8'd2,  rdat:8'hA5, exp_rd:1, exp_wr:0, exp_tmo:0, exp_busy:3};
    vecs[1] = '{m:1, rd:0, wr:1, addr:8'hFF, wdat:8'h3C, lat:8'd1,  rdat:8'h00, exp_rd:0, exp_wr:1, exp_tmo:0, exp_busy:2};
    vecs[2] = '{m:0, rd:1, wr:0, addr:8'h90, wdat:8'h00, lat:8'hFF, rdat:8'h00, exp_rd:1, exp_wr:0, exp_tmo:1, exp_busy:15};
    vecs[3] = '{m:0, rd:1, wr:1, addr:8'h55, wdat:8'h77, lat:8'd0,  rdat:8'h00, exp_rd:0, exp_wr:1, exp_tmo:0, exp_busy:1};
    vecs[4] = '{m:1, rd:1, wr:0, addr:8'h20, wdat:8'h11, lat:8'd14, rdat:8'h5A, exp_rd:1, exp_wr:0, exp_tmo:0, exp_busy:15};
    vecs[5] = '{m:1, rd:1, wr:0, addr:8'h33, wdat:8'h00, lat:8'd0,  rdat:8'hC3, exp_rd:1, exp_wr:0, exp_tmo:0, exp_busy:1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_bus", {read, write, address, data_out}, 32'd0);
    chk("rst_masters", {m0_ready, m1_ready, m0_data_in, m1_data_in}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Round-robin from a fresh reset: both keep requesting -> m0, m1, m0, m1, three cycles apart.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    slv_lat = 8'd0; slv_rdata = 8'h5A;
    set_m(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_m(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 4; k++) sb_q.push_back('{m: k[0], tmo: 1'b0, dat: 8'h5A});
    ng = 0; last_c = 0;
    for (int c = 1; c <= 30 && ng < 4; c++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        chk($sformatf("rr_order%0d", ng), grant, ng[0] ? 2'b10 : 2'b01);
        if (ng > 0) chk($sformatf("rr_gap%0d", ng), c - last_c, 3);
        last_c = c;
        ng++;
      end
    end
    chk("rr_count", ng, 4);
    @(posedge clk); #1;
    set_m(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Withdraw: m0 drops mid-wait -> RELEASE without timeout, and m0 becomes last served.
    @(posedge clk); #1;
    slv_lat = 8'hFF;
    set_m(1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
    wait_first_grant(2'b01, "wd_grant");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    set_m(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("wd_release", {grant, timeout, m0_ready}, 32'd0);
    @(negedge clk);
    chk("wd_idle_timeout", timeout, 1'b0);

    // Tie right after m0 was served -> m1 first.
    @(posedge clk); #1;
    slv_lat = 8'd0; slv_rdata = 8'h96;
    sb_q.push_back('{m: 1'b1, tmo: 1'b0, dat: 8'h96});
    set_m(1'b0, 1'b1, 1'b0, 8'h0A, 8'h00);
    set_m(1'b1, 1'b1, 1'b0, 8'h0B, 8'h00);
    wait_first_grant(2'b10, "tie_after_withdraw");
    @(posedge clk); #1;
    set_m(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Stray slave ready while unowned must not reach either master.
    force_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("unowned_rdy%0d", c), {grant, m0_ready, m1_ready, m0_data_in, m1_data_in}, 32'd0);
    end
    force_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during BUSY1: immediate quiet outputs, then m1 re-granted one cycle after release.
    @(posedge clk); #1;
    slv_lat = 8'hFF;
    set_m(1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
    wait_first_grant(2'b10, "rst_mid_grant");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {grant, read, write, address, data_out, m1_ready, m1_data_in, timeout}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", grant, 2'b00);
    @(negedge clk);
    chk("rst_mid_regrant", grant, 2'b10);
    @(posedge clk); #1;
    set_m(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
